// File: rtl/dm_present_pkg.sv
// Shared PRESENT primitives, key schedules and FSM encoding for the
// streaming Davies-Meyer hash engine.
package dm_present_pkg;

  localparam int BLOCK_W   = 64;
  localparam int KEY_W_80  = 80;
  localparam int KEY_W_128 = 128;
  localparam int RC_W      = 5;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN,
    OUT
  } state_t;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < BLOCK_W / 4; i++) y[4*i +: 4] = sbox(x[4*i +: 4]);
    return y;
  endfunction

  // Bit i moves to position 16*i mod 63; the top bit stays in place.
  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] x);
    logic [BLOCK_W-1:0] y;
    y = '0;
    for (int i = 0; i < BLOCK_W - 1; i++) y[(i * 16) % 63] = x[i];
    y[BLOCK_W-1] = x[BLOCK_W-1];
    return y;
  endfunction

  function automatic logic [KEY_W_80-1:0] update_key_80(input logic [KEY_W_80-1:0] k,
                                                        input logic [RC_W-1:0] rc);
    logic [KEY_W_80-1:0] r;
    r = {k[18:0], k[79:19]};
    r[79:76] = sbox(r[79:76]);
    r[19:15] = r[19:15] ^ rc;
    return r;
  endfunction

  function automatic logic [KEY_W_128-1:0] update_key_128(input logic [KEY_W_128-1:0] k,
                                                          input logic [RC_W-1:0] rc);
    logic [KEY_W_128-1:0] r;
    r = {k[66:0], k[127:67]};
    r[127:124] = sbox(r[127:124]);
    r[123:120] = sbox(r[123:120]);
    r[66:62] = r[66:62] ^ rc;
    return r;
  endfunction

endpackage

// File: rtl/present_round.sv
// One combinational PRESENT round together with the matching key-schedule step.
module present_round import dm_present_pkg::*; #(
  parameter int KEY_WIDTH = 128
) (
  input  logic [BLOCK_W-1:0]   s,
  input  logic [KEY_WIDTH-1:0] k,
  input  logic [RC_W-1:0]      rc,
  output logic [BLOCK_W-1:0]   s_next,
  output logic [KEY_WIDTH-1:0] k_next,
  output logic [BLOCK_W-1:0]   round_key
);

  assign round_key = k[KEY_WIDTH-1 -: BLOCK_W];
  assign s_next    = p_layer(sbox_layer(s ^ round_key));

  generate
    if (KEY_WIDTH == KEY_W_80) begin : g_key80
      assign k_next = update_key_80(k, rc);
    end else begin : g_key128
      assign k_next = update_key_128(k, rc);
    end
  endgenerate

endmodule

// File: rtl/dm_present_stream.sv
// Multi-block Davies-Meyer hash: the message block keys a round-serial PRESENT
// core that encrypts the chaining value, which is then fed forward.
module dm_present_stream import dm_present_pkg::*; #(
  parameter int KEY_WIDTH = 128,
  parameter int ROUNDS    = 31
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [KEY_WIDTH-1:0] in_block,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic [BLOCK_W-1:0]   iv,
  output logic [BLOCK_W-1:0]   hash,
  output logic                 hash_valid,
  input  logic                 hash_ready,
  output logic                 busy
);

  generate
    if (KEY_WIDTH != KEY_W_80 && KEY_WIDTH != KEY_W_128) begin : g_bad_key_width
      $error("dm_present_stream: KEY_WIDTH must be 80 or 128");
    end
    if (ROUNDS < 1 || ROUNDS > 31) begin : g_bad_rounds
      $error("dm_present_stream: ROUNDS must be in 1..31");
    end
  endgenerate

  localparam logic [RC_W-1:0] LAST_RC = RC_W'(ROUNDS);

  state_t               state, state_next;
  logic [BLOCK_W-1:0]   h, s, s_next, round_key;
  logic [KEY_WIDTH-1:0] k, k_next;
  logic [RC_W-1:0]      rc;
  logic                 last_r;

  present_round #(.KEY_WIDTH(KEY_WIDTH)) u_round (
    .s         (s),
    .k         (k),
    .rc        (rc),
    .s_next    (s_next),
    .k_next    (k_next),
    .round_key (round_key)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // in_ready is gated by reset so the engine never advertises space while held.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    hash_valid = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = reset;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (rc == LAST_RC) state_next = FIN;
      end
      FIN: begin
        busy       = 1'b1;
        state_next = last_r ? OUT : IDLE;
      end
      OUT: begin
        hash_valid = 1'b1;
        if (hash_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // After the last round k already holds the whitening key, so FIN folds it in
  // together with the Davies-Meyer feed-forward of the previous chaining value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h      <= '0;
      s      <= '0;
      k      <= '0;
      rc     <= '0;
      last_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            s      <= in_first ? iv : h;
            k      <= in_block;
            rc     <= RC_W'(1);
            last_r <= in_last;
            if (in_first) h <= iv;
          end
        end
        RUN: begin
          s  <= s_next;
          k  <= k_next;
          rc <= rc + RC_W'(1);
        end
        FIN:     h <= s ^ round_key ^ h;
        default: ;
      endcase
    end
  end

  assign hash = h;

endmodule

// File: tb/tb_dm_present_stream.sv
// Scoreboard bench for dm_present_stream: one 80-bit and one 128-bit key
// instance, directed blocks, and a monitor that checks every delivered digest.
module tb_dm_present_stream;

  localparam int ROUNDS = 31;
  localparam logic [63:0] SBOX_TBL  = 64'h21748FE3DA09B65C;
  localparam logic [63:0] H80_ZERO  = 64'h5579c1387b228445;
  localparam logic [63:0] H128_ZERO = 64'h96db702a2e6900af;
  localparam logic [63:0] IV_TXT    = 64'h4c746e677579656e;
  localparam logic [63:0] H128_IV   = 64'hd2d93e21b26f2b71;

  logic         clk;
  logic         reset;
  logic         in_valid   [2];
  logic         in_ready   [2];
  logic         in_first   [2];
  logic         in_last    [2];
  logic [63:0]  iv         [2];
  logic [63:0]  hash       [2];
  logic         hash_valid [2];
  logic         hash_ready [2];
  logic         busy       [2];
  logic [79:0]  block80;
  logic [127:0] block128;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q80  [$];
  logic [63:0] exp_q128 [$];

  dm_present_stream #(.KEY_WIDTH(80), .ROUNDS(ROUNDS)) dut80 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_block(block80), .in_first(in_first[0]), .in_last(in_last[0]), .iv(iv[0]),
    .hash(hash[0]), .hash_valid(hash_valid[0]), .hash_ready(hash_ready[0]), .busy(busy[0])
  );

  dm_present_stream #(.KEY_WIDTH(128), .ROUNDS(ROUNDS)) dut128 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_block(block128), .in_first(in_first[1]), .in_last(in_last[1]), .iv(iv[1]),
    .hash(hash[1]), .hash_valid(hash_valid[1]), .hash_ready(hash_ready[1]), .busy(busy[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference PRESENT, using the inverse permutation and a nibble lookup table.
  function automatic logic [3:0] ref_nib(input logic [3:0] v);
    return SBOX_TBL[4*int'(v) +: 4];
  endfunction

  function automatic logic [63:0] ref_sub(input logic [63:0] x);
    logic [63:0] y;
    for (int n = 0; n < 16; n++) y[4*n +: 4] = ref_nib(x[4*n +: 4]);
    return y;
  endfunction

  function automatic logic [63:0] ref_perm(input logic [63:0] x);
    logic [63:0] y;
    for (int j = 0; j < 63; j++) y[j] = x[(4 * j) % 63];
    y[63] = x[63];
    return y;
  endfunction

  function automatic logic [63:0] ref_present80(input logic [63:0] pt, input logic [79:0] key);
    logic [63:0] st;
    logic [79:0] k;
    st = pt;
    k  = key;
    for (int r = 1; r <= 31; r++) begin
      st = ref_perm(ref_sub(st ^ k[79:16]));
      k = {k[18:0], k[79:19]};
      k[79:76] = ref_nib(k[79:76]);
      k[19:15] = k[19:15] ^ r[4:0];
    end
    return st ^ k[79:16];
  endfunction

  function automatic logic [63:0] ref_present128(input logic [63:0] pt, input logic [127:0] key);
    logic [63:0] st;
    logic [127:0] k;
    st = pt;
    k  = key;
    for (int r = 1; r <= 31; r++) begin
      st = ref_perm(ref_sub(st ^ k[127:64]));
      k = {k[66:0], k[127:67]};
      k[127:124] = ref_nib(k[127:124]);
      k[123:120] = ref_nib(k[123:120]);
      k[66:62] = k[66:62] ^ r[4:0];
    end
    return st ^ k[127:64];
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input int d, input logic [127:0] blk, input logic [63:0] ivv,
                                input logic first, input logic last,
                                input logic push, input logic [63:0] exp);
    if (d == 0) block80 = blk[79:0];
    else        block128 = blk;
    iv[d]       = ivv;
    in_first[d] = first;
    in_last[d]  = last;
    in_valid[d] = 1'b1;
    if (push) begin
      if (d == 0) exp_q80.push_back(exp);
      else        exp_q128.push_back(exp);
    end
  endtask

  task automatic wait_accept(input int d);
    for (int i = 0; i < 100 && !in_ready[d]; i++) @(negedge clk);
    if (!in_ready[d]) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL accept timeout dut%0d: got in_ready=0, want 1", d);
    end
    @(posedge clk);
    #1 in_valid[d] = 1'b0;
  endtask

  // Sample i reflects the state after accept edge E0 + i clock edges.
  task automatic wait_done(input int d, input bit want_out, input string tag);
    int edges;
    int bad;
    edges = -1;
    bad   = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (want_out ? hash_valid[d] : in_ready[d]) begin
        edges = i;
        break;
      end
      if (in_ready[d] || hash_valid[d] || !busy[d]) bad++;
    end
    check_output({tag, " edges to done"}, 64'(edges), 64'(ROUNDS + 1));
    check_output({tag, " bad cycles while running"}, 64'(bad), 64'd0);
    if (want_out) check_output({tag, " in_ready in OUT"}, 64'(in_ready[d]), 64'd0);
    else          check_output({tag, " no hash_valid"}, 64'(hash_valid[d]), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      check_output($sformatf("%s dut%0d hash", tag, d), hash[d], 64'd0);
      check_output($sformatf("%s dut%0d hash_valid", tag, d), 64'(hash_valid[d]), 64'd0);
      check_output($sformatf("%s dut%0d in_ready", tag, d), 64'(in_ready[d]), 64'd0);
      check_output($sformatf("%s dut%0d busy", tag, d), 64'(busy[d]), 64'd0);
    end
  endtask

  always @(negedge clk) begin
    if (reset && hash_valid[0] && hash_ready[0]) begin
      if (exp_q80.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL hash80 unexpected: got %h, want no digest", hash[0]);
      end else check_output("hash80", hash[0], exp_q80.pop_front());
    end
  end

  always @(negedge clk) begin
    if (reset && hash_valid[1] && hash_ready[1]) begin
      if (exp_q128.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL hash128 unexpected: got %h, want no digest", hash[1]);
      end else check_output("hash128", hash[1], exp_q128.pop_front());
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got time limit reached, want end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] exp;
    int bad;
    reset    = 1'b0;
    block80  = '0;
    block128 = '0;
    for (int d = 0; d < 2; d++) begin
      in_valid[d]   = 1'b0;
      in_first[d]   = 1'b0;
      in_last[d]    = 1'b0;
      iv[d]         = '0;
      hash_ready[d] = 1'b1;
    end

    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b1;
    @(negedge clk);
    check_output("idle ready dut80", 64'(in_ready[0]), 64'd1);
    check_output("idle ready dut128", 64'(in_ready[1]), 64'd1);

    $display("[TB] single block, 80-bit key");
    @(posedge clk); #1;
    apply_stimulus(0, '0, '0, 1'b1, 1'b1, 1'b1, H80_ZERO);
    wait_accept(0);
    wait_done(0, 1'b1, "k80 single");

    $display("[TB] single block, 128-bit key, zero iv");
    @(posedge clk); #1;
    apply_stimulus(1, '0, '0, 1'b1, 1'b1, 1'b1, H128_ZERO);
    wait_accept(1);
    wait_done(1, 1'b1, "k128 single");

    $display("[TB] single block, 128-bit key, text iv");
    @(posedge clk); #1;
    apply_stimulus(1, '0, IV_TXT, 1'b1, 1'b1, 1'b1, H128_IV);
    wait_accept(1);
    wait_done(1, 1'b1, "k128 iv");

    // Block 2 is offered while block 1 runs, so it is taken on the first ready edge.
    $display("[TB] two-block message, 80-bit key");
    @(posedge clk); #1;
    apply_stimulus(0, '0, '0, 1'b1, 1'b0, 1'b0, '0);
    wait_accept(0);
    exp = ref_present80(H80_ZERO, '0) ^ H80_ZERO;
    apply_stimulus(0, '0, 64'hffff_ffff_ffff_ffff, 1'b0, 1'b1, 1'b1, exp);
    wait_done(0, 1'b0, "k80 block1");
    wait_accept(0);
    wait_done(0, 1'b1, "k80 block2");

    $display("[TB] digest backpressure");
    hash_ready[1] = 1'b0;
    @(posedge clk); #1;
    apply_stimulus(1, '0, '0, 1'b1, 1'b1, 1'b1, H128_ZERO);
    wait_accept(1);
    wait_done(1, 1'b1, "k128 bp");
    @(posedge clk); #1;
    apply_stimulus(1, {4{32'h0f1e2d3c}}, 64'h0123_4567_89ab_cdef, 1'b1, 1'b1, 1'b0, '0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hash[1] !== H128_ZERO || !hash_valid[1] || in_ready[1] || busy[1]) bad++;
    end
    check_output("bp held cycles bad", 64'(bad), 64'd0);
    @(posedge clk); #1;
    in_valid[1]   = 1'b0;
    hash_ready[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("bp release hash_valid", 64'(hash_valid[1]), 64'd0);
    check_output("bp release in_ready", 64'(in_ready[1]), 64'd1);

    $display("[TB] incremental block continues from digest");
    @(posedge clk); #1;
    exp = ref_present128(H128_ZERO, '0) ^ H128_ZERO;
    apply_stimulus(1, '0, 64'hffff_ffff_ffff_ffff, 1'b0, 1'b1, 1'b1, exp);
    wait_accept(1);
    wait_done(1, 1'b1, "k128 incr");

    $display("[TB] reset during a running block");
    @(posedge clk); #1;
    apply_stimulus(1, {4{32'hdeadbeef}}, 64'h1111_2222_3333_4444, 1'b1, 1'b1, 1'b0, '0);
    wait_accept(1);
    repeat (9) @(posedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    check_reset_outputs("abort held");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    apply_stimulus(1, '0, '0, 1'b1, 1'b1, 1'b1, H128_ZERO);
    wait_accept(1);
    wait_done(1, 1'b1, "k128 after abort");

    repeat (3) @(negedge clk);
    check_output("scoreboard80 drained", 64'(exp_q80.size()), 64'd0);
    check_output("scoreboard128 drained", 64'(exp_q128.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
